store_merge_buffer: RTL

Parametrised post-commit store buffer between the store pipeline and the data cache. Each accepted store is byte-aligned into a cache-line-wide data and write-mask pair, queued in a FIFO of line-granular entries, merged into the youngest entry when it targets the same line, and drained in order to the cache over a valid/ready handshake. A line-address lookup port lets the load unit detect pending stores to a line and stall.

---
 rtl/store_merge_buffer_pkg.sv | 39 +++
 rtl/store_merge_buffer_if.sv | 43 ++++
 rtl/store_merge_buffer_store_line_aligner.sv | 30 +++
 rtl/store_merge_buffer.sv | 107 ++++++++++
 4 files changed

// File: rtl/store_merge_buffer_pkg.sv
// Shared types for the post-commit store merge buffer: access types, the
// access-size decode and the default-configuration entry layout.
package store_merge_buffer_pkg;

  localparam int DCACHE_LINE_SIZE = 16;
  localparam int DEFAULT_PADDR_WIDTH = 34;
  localparam int DEFAULT_OFFSET_WIDTH = $clog2(DCACHE_LINE_SIZE);

  typedef enum logic [3:0] {
    Byte,
    UnsignedByte,
    HalfWord,
    UnsignedHalfWord,
    Word,
    UnsignedWord,
    FpWord,
    DoubleWord,
    None
  } LoadStoreType;

  // Entry layout for the default line size and address width.
  typedef struct packed {
    logic                                            valid;
    logic [DEFAULT_PADDR_WIDTH-DEFAULT_OFFSET_WIDTH-1:0] lineAddr;
    logic [DCACHE_LINE_SIZE*8-1:0]                   line;
    logic [DCACHE_LINE_SIZE-1:0]                     writeMask;
  } StoreBufferEntry;

  function automatic logic [3:0] AccessSizeOf(LoadStoreType t);
    case (t)
      Byte, UnsignedByte:           return 4'd1;
      HalfWord, UnsignedHalfWord:   return 4'd2;
      Word, UnsignedWord, FpWord:   return 4'd4;
      DoubleWord:                   return 4'd8;
      default:                      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_merge_buffer_if.sv
// Bus bundle between the store pipeline / load unit / data cache and the
// store merge buffer.
interface store_merge_buffer_if
  import store_merge_buffer_pkg::*;
#(
    parameter int LINE_SIZE   = DCACHE_LINE_SIZE,
    parameter int PADDR_WIDTH = DEFAULT_PADDR_WIDTH
);
    localparam int LINE_WIDTH      = LINE_SIZE * 8;
    localparam int OFFSET_WIDTH    = $clog2(LINE_SIZE);
    localparam int LINE_ADDR_WIDTH = PADDR_WIDTH - OFFSET_WIDTH;

    // Both handshakes: a transfer happens on a rising edge where valid and
    // ready are both high; the offering side keeps payload stable until then.
    logic                       enqueueValid;
    logic                       enqueueReady;
    logic [PADDR_WIDTH-1:0]     enqueueAddr;
    logic [63:0]                enqueueValue;
    LoadStoreType               enqueueLoadStoreType;
    logic                       drainValid;
    logic                       drainReady;
    logic [LINE_ADDR_WIDTH-1:0] drainLineAddr;
    logic [LINE_WIDTH-1:0]      drainLine;
    logic [LINE_SIZE-1:0]       drainWriteMask;
    logic [LINE_ADDR_WIDTH-1:0] lookupLineAddr;
    logic                       lookupHit;
    logic                       empty;

    modport master (
        output enqueueValid, enqueueAddr, enqueueValue, enqueueLoadStoreType,
        output drainReady, lookupLineAddr,
        input  enqueueReady, drainValid, drainLineAddr, drainLine,
        input  drainWriteMask, lookupHit, empty
    );

    modport slave (
        input  enqueueValid, enqueueAddr, enqueueValue, enqueueLoadStoreType,
        input  drainReady, lookupLineAddr,
        output enqueueReady, drainValid, drainLineAddr, drainLine,
        output drainWriteMask, lookupHit, empty
    );

endinterface

// File: rtl/store_merge_buffer_store_line_aligner.sv
// Places a right-justified store value at its byte offset inside a
// cache-line-wide data word and builds the matching byte-enable mask.
module store_line_aligner #(
    parameter int LINE_SIZE = 16,
    localparam int OFFSET_WIDTH = $clog2(LINE_SIZE)
) (
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic [3:0]              size,
    input  logic [63:0]             value,
    output logic [LINE_SIZE*8-1:0]  line,
    output logic [LINE_SIZE-1:0]    mask
);

    logic [2:0] rel;

    // Bytes that would fall past the line end simply never match a lane.
    always_comb begin
        line = '0;
        mask = '0;
        rel  = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (i >= int'(offset) && i < int'(offset) + int'(size)) begin
                rel              = 3'(i - int'(offset));
                mask[i]          = 1'b1;
                line[8*i +: 8]   = value[8*rel +: 8];
            end
        end
    end

endmodule

// File: rtl/store_merge_buffer.sv
// Post-commit store buffer: line-granular FIFO that merges same-line stores
// into the youngest entry, drains in order and answers pending-line lookups.
module store_merge_buffer
  import store_merge_buffer_pkg::*;
#(
    parameter int LINE_SIZE   = DCACHE_LINE_SIZE,
    parameter int ENTRY_COUNT = 4,
    parameter int PADDR_WIDTH = DEFAULT_PADDR_WIDTH
) (
    input  logic clk,
    input  logic rst,
    store_merge_buffer_if.slave bus
);

    localparam int LINE_WIDTH      = LINE_SIZE * 8;
    localparam int OFFSET_WIDTH    = $clog2(LINE_SIZE);
    localparam int LINE_ADDR_WIDTH = PADDR_WIDTH - OFFSET_WIDTH;
    localparam int PTR_WIDTH       = $clog2(ENTRY_COUNT);
    localparam int COUNT_WIDTH     = $clog2(ENTRY_COUNT + 1);

    typedef struct packed {
        logic                       valid;
        logic [LINE_ADDR_WIDTH-1:0] lineAddr;
        logic [LINE_WIDTH-1:0]      line;
        logic [LINE_SIZE-1:0]       writeMask;
    } entry_t;

    entry_t                     entries [ENTRY_COUNT];
    logic [PTR_WIDTH-1:0]       head, tail, youngest;
    logic [COUNT_WIDTH-1:0]     count;

    logic [3:0]                 store_size;
    logic [LINE_ADDR_WIDTH-1:0] store_line_addr;
    logic [LINE_WIDTH-1:0]      store_line;
    logic [LINE_SIZE-1:0]       store_mask;
    logic                       full, store_write, merge, alloc, drain_fire;

    assign store_size      = AccessSizeOf(bus.enqueueLoadStoreType);
    assign store_line_addr = bus.enqueueAddr[PADDR_WIDTH-1:OFFSET_WIDTH];

    store_line_aligner #(.LINE_SIZE(LINE_SIZE)) u_aligner (
        .offset (bus.enqueueAddr[OFFSET_WIDTH-1:0]),
        .size   (store_size),
        .value  (bus.enqueueValue),
        .line   (store_line),
        .mask   (store_mask)
    );

    assign full        = (count == COUNT_WIDTH'(ENTRY_COUNT));
    assign youngest    = tail - PTR_WIDTH'(1);
    assign drain_fire  = bus.drainValid && bus.drainReady;
    // Size-0 stores are accepted but leave the buffer untouched.
    assign store_write = bus.enqueueValid && !full && (store_size != 4'd0);
    // Requiring two entries keeps the head out of merging, so drain payload
    // never changes under a stalled handshake.
    assign merge       = store_write && (count >= COUNT_WIDTH'(2)) &&
                         entries[youngest].valid &&
                         (entries[youngest].lineAddr == store_line_addr);
    assign alloc       = store_write && !merge;

    assign bus.enqueueReady   = !full;
    assign bus.drainValid     = (count != '0);
    assign bus.empty          = (count == '0);
    assign bus.drainLineAddr  = entries[head].lineAddr;
    assign bus.drainLine      = entries[head].line;
    assign bus.drainWriteMask = entries[head].writeMask;

    always_comb begin
        bus.lookupHit = 1'b0;
        for (int i = 0; i < ENTRY_COUNT; i++) begin
            if (entries[i].valid && entries[i].lineAddr == bus.lookupLineAddr)
                bus.lookupHit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ENTRY_COUNT; i++) entries[i].valid <= 1'b0;
        end else begin
            if (drain_fire) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_WIDTH'(1);
            end
            if (merge) begin
                for (int i = 0; i < LINE_SIZE; i++) begin
                    if (store_mask[i])
                        entries[youngest].line[8*i +: 8] <= store_line[8*i +: 8];
                end
                entries[youngest].writeMask <= entries[youngest].writeMask | store_mask;
            end
            if (alloc) begin
                entries[tail] <= '{valid: 1'b1, lineAddr: store_line_addr,
                                   line: store_line, writeMask: store_mask};
                tail          <= tail + PTR_WIDTH'(1);
            end
            case ({alloc, drain_fire})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
